// File: rtl/regfile_mp.sv
// regfile_mp: register file with NUM_RD combinational read ports, two write ports,
// optional write-to-read bypass and a self-clearing sequence after reset.
module regfile_mp #(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int NUM_RD = 2,
   parameter bit BYPASS = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        busy,
   input  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr,
   output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
   input  logic                        we0,
   input  logic [ADDR_SIZE-1:0]        waddr0,
   input  logic [WORD_SIZE-1:0]        wdata0,
   input  logic                        we1,
   input  logic [ADDR_SIZE-1:0]        waddr1,
   input  logic [WORD_SIZE-1:0]        wdata1
);
   localparam int NREG = 2**ADDR_SIZE;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t state_q;
   logic [ADDR_SIZE-1:0] cnt_q;
   logic [WORD_SIZE-1:0] mem_q [NREG-1:1];
   logic run_we0, run_we1;
   assign busy = state_q == CLEAR;
   assign run_we0 = !busy && we0 && waddr0 != '0;
   assign run_we1 = !busy && we1 && waddr1 != '0;
   // port 1 is assigned last so it wins a same-address conflict
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q <= ADDR_SIZE'(1);
      end else if (busy) begin
         mem_q[cnt_q] <= '0;
         if (cnt_q == '1) state_q <= RUN;
         else cnt_q <= cnt_q + 1'b1;
      end else begin
         if (run_we0) mem_q[waddr0] <= wdata0;
         if (run_we1) mem_q[waddr1] <= wdata1;
      end
   end
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_SIZE-1:0] a;
      assign a = rd_addr[p*ADDR_SIZE +: ADDR_SIZE];
      assign rd_data[p*WORD_SIZE +: WORD_SIZE] =
         (busy || a == '0)                   ? '0     :
         (BYPASS && run_we1 && waddr1 == a) ? wdata1 :
         (BYPASS && run_we0 && waddr0 == a) ? wdata0 : mem_q[a];
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks bypass and non-bypass instances against an array model of the register file.
module tb_regfile_mp;
   localparam int A = 5, W = 32, N = 2, R = 32;
   logic clk = 0, rst = 0, we0 = 0, we1 = 0;
   logic [A-1:0] waddr0 = 0, waddr1 = 0;
   logic [W-1:0] wdata0 = 0, wdata1 = 0;
   logic [N*A-1:0] rd_addr = 0;
   logic [N*W-1:0] rd_data, rd_data_nb;
   logic busy, busy_nb;
   int n_cmp = 0, n_err = 0;
   logic [W-1:0] m [R];
   int pending = 31;

   regfile_mp #(.ADDR_SIZE(A), .WORD_SIZE(W), .NUM_RD(N), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1));
   regfile_mp #(.ADDR_SIZE(A), .WORD_SIZE(W), .NUM_RD(N), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .busy(busy_nb), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1));

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic e0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                        input logic e1, input logic [A-1:0] a1, input logic [W-1:0] d1);
      rst = r; we0 = e0; waddr0 = a0; wdata0 = d0; we1 = e1; waddr1 = a1; wdata1 = d1;
   endtask

   task automatic set_rd(input logic [A-1:0] r0, input logic [A-1:0] r1);
      rd_addr = {r1, r0};
   endtask

   // model: reset arms a 31-cycle clear, after which every register is zero
   task automatic tick;
      @(posedge clk);
      if (rst) pending = 31;
      else if (pending > 0) begin
         pending--;
         if (pending == 0) for (int i = 0; i < R; i++) m[i] = '0;
      end else begin
         if (we0 && waddr0 != 0) m[waddr0] = wdata0;
         if (we1 && waddr1 != 0) m[waddr1] = wdata1;
      end
      @(negedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a, input bit byp);
      if (pending > 0 || a == 0) return '0;
      if (byp && we1 && waddr1 == a) return wdata1;
      if (byp && we0 && waddr0 == a) return wdata0;
      return m[a];
   endfunction

   task automatic pulse_rst;
      drive(1, 0, 0, 0, 0, 0, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset;
      int cyc = 0;
      pulse_rst;
      while (busy === 1'b1 && cyc < 100) begin
         set_rd(A'($urandom), A'($urandom));
         #1;
         for (int p = 0; p < N; p++) begin
            n_cmp++;
            if (rd_data[p*W +: W] !== '0 || rd_data_nb[p*W +: W] !== '0) begin
               n_err++;
               $display("FAIL reset_busy_read p%0d: got %h/%h expected 0", p, rd_data[p*W +: W], rd_data_nb[p*W +: W]);
            end
         end
         cyc++;
         tick;
      end
      n_cmp++;
      if (cyc !== 31) begin
         n_err++;
         $display("FAIL reset_busy_len: got %0d expected 31", cyc);
      end
      for (int a = 0; a < R; a++) begin
         set_rd(A'(a), A'(a));
         #1;
         n_cmp++;
         if (rd_data !== '0 || rd_data_nb !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_all_zero a%0d: got %h/%h busy %b expected 0/0 busy 0", a, rd_data, rd_data_nb, busy);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         logic [A-1:0] a0, a1, r0, r1;
         a0 = ($urandom_range(0, 1) == 1) ? A'($urandom_range(0, 7)) : A'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : A'($urandom_range(0, 7));
         r0 = ($urandom_range(0, 1) == 1) ? a0 : A'($urandom_range(0, 7));
         r1 = ($urandom_range(0, 1) == 1) ? a1 : r0;
         drive(0, 1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom);
         set_rd(r0, r1);
         #1;
         n_cmp++;
         if (busy !== (pending > 0)) begin
            n_err++;
            $display("FAIL rand_busy: got %b expected %b", busy, pending > 0);
         end
         for (int p = 0; p < N; p++) begin
            logic [A-1:0] a;
            a = rd_addr[p*A +: A];
            n_cmp++;
            if (rd_data[p*W +: W] !== exp_rd(a, 1) || rd_data_nb[p*W +: W] !== exp_rd(a, 0)) begin
               n_err++;
               $display("FAIL rand_read p%0d a%0d: got %h/%h expected %h/%h", p, a,
                        rd_data[p*W +: W], rd_data_nb[p*W +: W], exp_rd(a, 1), exp_rd(a, 0));
            end
         end
         tick;
      end
   endtask

   task automatic test_conflict;
      drive(0, 1, 7, 32'h11111111, 1, 7, 32'h22222222);
      set_rd(7, 7);
      #1;
      n_cmp++;
      if (rd_data !== {2{32'h22222222}} || rd_data_nb !== {2{m[7]}}) begin
         n_err++;
         $display("FAIL conflict_same: got %h/%h expected %h/%h", rd_data, rd_data_nb, {2{32'h22222222}}, {2{m[7]}});
      end
      tick;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (rd_data !== {2{32'h22222222}} || rd_data_nb !== {2{32'h22222222}}) begin
         n_err++;
         $display("FAIL conflict_next: got %h/%h expected 22222222", rd_data, rd_data_nb);
      end
   endtask

   task automatic test_bypass;
      drive(0, 1, 5, 32'hA, 0, 0, 0);
      tick;
      drive(0, 1, 5, 32'hB, 0, 0, 0);
      set_rd(5, 0);
      #1;
      n_cmp++;
      if (rd_data[W-1:0] !== 32'hB || rd_data_nb[W-1:0] !== 32'hA) begin
         n_err++;
         $display("FAIL bypass_same: got %h/%h expected 0000000b/0000000a", rd_data[W-1:0], rd_data_nb[W-1:0]);
      end
      tick;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (rd_data[W-1:0] !== 32'hB || rd_data_nb[W-1:0] !== 32'hB) begin
         n_err++;
         $display("FAIL bypass_next: got %h/%h expected 0000000b", rd_data[W-1:0], rd_data_nb[W-1:0]);
      end
   endtask

   task automatic test_zero;
      drive(0, 1, 0, 32'h12345678, 1, 0, 32'hFFFFFFFF);
      set_rd(0, 0);
      #1;
      n_cmp++;
      if (rd_data !== '0 || rd_data_nb !== '0) begin
         n_err++;
         $display("FAIL zero_same: got %h/%h expected 0", rd_data, rd_data_nb);
      end
      tick;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++;
      if (rd_data !== '0 || rd_data_nb !== '0) begin
         n_err++;
         $display("FAIL zero_after: got %h/%h expected 0", rd_data, rd_data_nb);
      end
   endtask

   task automatic test_busy_gating;
      int cyc = 0;
      drive(0, 1, 3, 32'h77, 0, 0, 0);
      tick;
      pulse_rst;
      while (busy === 1'b1 && cyc < 100) begin
         if (cyc == 9) drive(0, 1, 3, 32'h5, 0, 0, 0);
         else drive(0, 0, 0, 0, 0, 0, 0);
         cyc++;
         tick;
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      set_rd(3, 3);
      #1;
      n_cmp++;
      if (cyc !== 31 || rd_data !== '0 || rd_data_nb !== '0) begin
         n_err++;
         $display("FAIL busy_gating: got len %0d r3 %h/%h expected len 31 r3 0", cyc, rd_data, rd_data_nb);
      end
   endtask

   task automatic test_midclear;
      int cyc = 0;
      drive(0, 1, 9, 32'h12345678, 0, 0, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0, 0);
      set_rd(9, 9);
      #1;
      n_cmp++;
      if (rd_data[W-1:0] !== 32'h12345678) begin
         n_err++;
         $display("FAIL midclear_store: got %h expected 12345678", rd_data[W-1:0]);
      end
      pulse_rst;
      repeat (20) tick;
      pulse_rst;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         tick;
      end
      n_cmp++;
      if (cyc !== 31 || rd_data !== '0 || rd_data_nb !== '0) begin
         n_err++;
         $display("FAIL midclear: got len %0d r9 %h/%h expected len 31 r9 0", cyc, rd_data, rd_data_nb);
      end
   endtask

   initial begin
      for (int i = 0; i < R; i++) m[i] = '0;
      @(negedge clk);
      #1;
      test_reset;
      test_random;
      test_conflict;
      test_bypass;
      test_zero;
      test_random;
      test_busy_gating;
      test_midclear;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 5, register address width; the file holds 2**ADDR_SIZE registers, with register 0 hardwired to zero.
REQ-002 SHALL have parameter WORD_SIZE, default 32, data width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (range 1..8).
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes forward to reads.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port busy, output, 1 bit, high while the clear sequence runs.
REQ-008 SHALL have port rd_addr, input, NUM_RD*ADDR_SIZE bits; port p uses bits [p*ADDR_SIZE +: ADDR_SIZE].
REQ-009 SHALL have port rd_data, output, NUM_RD*WORD_SIZE bits; port p uses bits [p*WORD_SIZE +: WORD_SIZE].
REQ-010 SHALL have ports we0/waddr0/wdata0, inputs, 1/ADDR_SIZE/WORD_SIZE bits, write port 0 (ALU writeback).
REQ-011 SHALL have ports we1/waddr1/wdata1, inputs, 1/ADDR_SIZE/WORD_SIZE bits, write port 1 (load writeback).

Function
REQ-012 SHALL implement a two-state controller with states CLEAR and RUN.
REQ-013 In CLEAR, a counter starting at 1 SHALL write zero to register [counter] each cycle and increment.
REQ-014 The controller SHALL go CLEAR->RUN on the edge that clears register 2**ADDR_SIZE-1, i.e. after exactly 2**ADDR_SIZE-1 CLEAR cycles.
REQ-015 The counter SHALL NOT wrap to 0.
REQ-016 busy SHALL be 1 in CLEAR and 0 in RUN (combinational from state).
REQ-017 While busy=1, we0 and we1 SHALL be ignored.
REQ-018 While busy=1, every rd_data port SHALL read 0.
REQ-019 In RUN, on a rising edge with weN=1 and waddrN!=0, register waddrN SHALL take wdataN.
REQ-020 Writes to address 0 SHALL be discarded on either write port.
REQ-021 When both write ports are enabled for the same nonzero address, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-022 When both write ports are enabled for different addresses, both writes SHALL commit on the same edge.
REQ-023 Reads SHALL be combinational (zero-cycle latency).
REQ-024 A read of address 0 SHALL return 0 regardless of any write activity.
REQ-025 With BYPASS=1 in RUN, a read of a nonzero address matching an enabled write address SHALL return that write's data in the same cycle.
REQ-026 For bypass, a port-1 match SHALL take priority over a port-0 match.
REQ-027 With BYPASS=0, a read SHALL return the pre-edge stored value; new data becomes visible the cycle after the write.
REQ-028 All NUM_RD read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-029 Storage SHALL hold 2**ADDR_SIZE-1 physical words; register 0 SHALL NOT be stored.

Reset
REQ-030 A sampled rst=1 SHALL put the controller in CLEAR with the counter at 1; busy SHALL be 1 while rst is high.
REQ-031 rst=1 SHALL take priority over all writes in the same cycle.
REQ-032 rst asserted mid-CLEAR SHALL restart the sequence from register 1.
REQ-033 rst asserted mid-RUN SHALL abandon contents; all registers SHALL read 0 once busy falls.
REQ-034 Outputs after reset: busy=1 and rd_data all zero until the clear completes.

Verification
REQ-035 Reset sequence: ADDR_SIZE=5, pulse rst one cycle -> busy=1 for exactly 31 cycles after rst falls; then all 32 addresses read 0.
REQ-036 Dual-write conflict: we0=we1=1, waddr0=waddr1=7, wdata0=0x11111111, wdata1=0x22222222 -> next cycle r7 reads 0x22222222.
REQ-037 Bypass: BYPASS=1, r5=0xA, we0=1, waddr0=5, wdata0=0xB, rd port0 addr 5 -> same cycle 0xB; with BYPASS=0 -> 0xA, then 0xB next cycle.
REQ-038 Zero register: we1=1, waddr1=0, wdata1=0xFFFFFFFF -> all ports reading addr 0 return 0 in the write cycle and after.
REQ-039 Busy gating: we0=1, waddr0=3, wdata0=0x5 during cycle 10 of clear -> r3 reads 0 after busy falls.
REQ-040 Mid-clear reset: assert rst at clear cycle 20 -> busy stays 1 for a further 31 cycles after rst falls; a stored value written before the first reset reads 0.
